// File: rtl/clk_reset_pkg.sv
// Shared constants and the divider-channel state record for the clock/reset generator.
package clk_reset_pkg;

    localparam int CNT_W_DEFAULT     = 16;
    localparam int DIV_DEFAULT       = 500;
    localparam int DELAY_BIT_DEFAULT = 15;
    localparam int SYNC_STAGES       = 2;

    // Divider channel state at the default counter width.
    typedef struct packed {
        logic [CNT_W_DEFAULT-1:0] cnt;
        logic [CNT_W_DEFAULT-1:0] div_act;
        logic [CNT_W_DEFAULT-1:0] div_pend;
        logic                     pend_vld;
        logic                     clk_q;
    } div_ch_t;

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: terminal counter, glitch-free divisor reload and a 50% duty toggle flop.
module clk_div_channel
    import clk_reset_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int DEFAULT_DIV = DIV_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] value_i,
    output logic             clk_o,
    output logic             tick_o
);

    // Same field layout as clk_reset_pkg::div_ch_t, sized by CNT_W.
    typedef struct packed {
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] div_act;
        logic [CNT_W-1:0] div_pend;
        logic             pend_vld;
        logic             clk_q;
    } ch_state_t;

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

    ch_state_t state_q, state_d;
    logic      tick_q, tick_d;
    logic      terminal;

    assign terminal = en_i && (state_q.cnt == state_q.div_act);

    // Next-state: count, toggle on terminal, and swap in a new divisor only at a period boundary.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_d = state_q;
        tick_d  = 1'b0;
        if (clr_i) begin
            // Held in reset by a button request; divisors survive, everything else clears.
            state_d.cnt      = '0;
            state_d.clk_q    = 1'b0;
            state_d.pend_vld = 1'b0;
        end else begin
            if (!en_i) begin
                state_d.cnt   = '0;
                state_d.clk_q = 1'b0;
            end else if (terminal) begin
                state_d.cnt   = '0;
                state_d.clk_q = ~state_q.clk_q;
                tick_d        = 1'b1;
            end else begin
                state_d.cnt = state_q.cnt + 1'b1;
            end

            if (load_i) begin
                state_d.div_pend = value_i;
                if (terminal || !en_i) begin
                    state_d.div_act  = value_i;
                    state_d.pend_vld = 1'b0;
                end else begin
                    state_d.pend_vld = 1'b1;
                end
            end else if (state_q.pend_vld && (terminal || !en_i)) begin
                state_d.div_act  = state_q.div_pend;
                state_d.pend_vld = 1'b0;
            end
        end
    end

    // Channel state register with asynchronous master reset.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            state_q <= '{cnt: '0, div_act: DIV_RST, div_pend: DIV_RST, pend_vld: 1'b0, clk_q: 1'b0};
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
        end
    end

    assign clk_o  = state_q.clk_q;
    assign tick_o = tick_q;

endmodule

// File: rtl/clk_reset_gen.sv
// Board clock-enable and reset sequencer: NUM_CH divided clocks plus a stretched DUT reset.
module clk_reset_gen
    import clk_reset_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int DEFAULT_DIV = DIV_DEFAULT,
    parameter int DELAY_BIT   = DELAY_BIT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_rst_req,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic [NUM_CH-1:0] div_load,
    input  logic [CNT_W-1:0]  div_value,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick_out,
    output logic              rst_out,
    output logic              rst_done
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   int_clr;
    logic [DELAY_BIT:0]     dly_cnt_q, dly_cnt_d;
    logic                   rst_q, rst_d;
    logic                   done_q, done_d;

    assign sync_d  = {sync_q[SYNC_STAGES-2:0], btn_rst_req};
    assign int_clr = sync_q[SYNC_STAGES-1];

    // Two-flop synchroniser for the asynchronous button request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    // Delay sequencer: count up to bit DELAY_BIT once, then release the DUT reset and freeze.
    always_comb begin
        dly_cnt_d = dly_cnt_q;
        rst_d     = rst_q;
        done_d    = 1'b0;
        if (int_clr) begin
            dly_cnt_d = '0;
            rst_d     = 1'b1;
        end else if (!dly_cnt_q[DELAY_BIT]) begin
            dly_cnt_d = dly_cnt_q + 1'b1;
            if (dly_cnt_d[DELAY_BIT]) begin
                rst_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    // Sequencer registers; the DUT reset comes up asserted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dly_cnt_q <= '0;
            rst_q     <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            dly_cnt_q <= dly_cnt_d;
            rst_q     <= rst_d;
            done_q    <= done_d;
        end
    end

    // The request is OR-ed in so rst_out rises as soon as the synchroniser output does.
    assign rst_out  = rst_q | int_clr;
    assign rst_done = done_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clk_div_channel #(
            .CNT_W      (CNT_W),
            .DEFAULT_DIV(DEFAULT_DIV)
        ) u_ch (
            .clk    (clk),
            .reset  (reset),
            .clr_i  (int_clr),
            .en_i   (ch_en[g]),
            .load_i (div_load[g]),
            .value_i(div_value),
            .clk_o  (clk_out[g]),
            .tick_o (tick_out[g])
        );
    end

endmodule

// File: tb/tb_clk_reset_gen.sv
// Directed bench for clk_reset_gen: scoreboard of expected half-period lengths per channel
// plus a per-cycle expectation for the reset sequencer outputs.
module tb_clk_reset_gen;

    localparam int NUM_CH      = 2;
    localparam int CNT_W       = 8;
    localparam int DEFAULT_DIV = 2;
    localparam int DELAY_BIT   = 3;
    localparam int DELAY       = 1 << DELAY_BIT;
    localparam int SYNC_LAT    = 2;
    localparam int NPUSH       = 30;

    logic              clk = 1'b0;
    logic              reset;
    logic              btn_rst_req;
    logic [NUM_CH-1:0] ch_en;
    logic [NUM_CH-1:0] div_load;
    logic [CNT_W-1:0]  div_value;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick_out;
    logic              rst_out;
    logic              rst_done;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Scoreboard: expected half-period lengths, one queue per channel.
    int sb0[$];
    int sb1[$];
    int last_tog[NUM_CH];
    int clr_at[NUM_CH];
    logic exp_clk[NUM_CH];
    int rst_hi_from;
    int rst_rel_at;

    clk_reset_gen #(
        .NUM_CH     (NUM_CH),
        .CNT_W      (CNT_W),
        .DEFAULT_DIV(DEFAULT_DIV),
        .DELAY_BIT  (DELAY_BIT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_rst_req(btn_rst_req),
        .ch_en      (ch_en),
        .div_load   (div_load),
        .div_value  (div_value),
        .clk_out    (clk_out),
        .tick_out   (tick_out),
        .rst_out    (rst_out),
        .rst_done   (rst_done)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic sb_push(input int c, input int len, input int n);
        for (int i = 0; i < n; i++) begin
            if (c == 0) sb0.push_back(len);
            else        sb1.push_back(len);
        end
    endtask

    function automatic int sb_size(input int c);
        return (c == 0) ? sb0.size() : sb1.size();
    endfunction

    function automatic int sb_front(input int c);
        if (sb_size(c) == 0) return 0;
        return (c == 0) ? sb0[0] : sb1[0];
    endfunction

    task automatic sb_pop(input int c);
        if (c == 0) void'(sb0.pop_front());
        else        void'(sb1.pop_front());
    endtask

    task automatic sb_flush(input int c);
        if (c == 0) sb0.delete();
        else        sb1.delete();
    endtask

    // A new divisor never cuts the half-period in progress: keep only the next toggle.
    task automatic replan(input int c, input int new_len);
        if (c == 0) while (sb0.size() > 1) void'(sb0.pop_back());
        else        while (sb1.size() > 1) void'(sb1.pop_back());
        sb_push(c, new_len, NPUSH);
    endtask

    // Advance one clock and compare every output against the bench expectations.
    task automatic step();
        bit tog;
        @(negedge clk);
        cyc++;
        for (int c = 0; c < NUM_CH; c++) begin
            if (cyc == clr_at[c]) begin
                sb_flush(c);
                exp_clk[c]  = 1'b0;
                last_tog[c] = cyc;
                clr_at[c]   = -1;
            end
            tog = (sb_size(c) != 0) && (cyc == last_tog[c] + sb_front(c));
            if (tog) begin
                sb_pop(c);
                last_tog[c] = cyc;
                exp_clk[c]  = ~exp_clk[c];
            end
            check($sformatf("tick_out[%0d]", c), 32'(tick_out[c]), 32'(tog));
            check($sformatf("clk_out[%0d]", c), 32'(clk_out[c]), 32'(exp_clk[c]));
        end
        check("rst_out", 32'(rst_out), 32'((cyc >= rst_hi_from) && (cyc < rst_rel_at)));
        check("rst_done", 32'(rst_done), 32'(cyc == rst_rel_at));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        reset       = 1'b1;
        btn_rst_req = 1'b0;
        ch_en       = '0;
        div_load    = '0;
        div_value   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            last_tog[c] = 0;
            clr_at[c]   = -1;
            exp_clk[c]  = 1'b0;
        end
        rst_hi_from = 0;
        rst_rel_at  = DELAY;

        repeat (3) @(negedge clk);
        check("reset clk_out", 32'(clk_out), 32'(0));
        check("reset tick_out", 32'(tick_out), 32'(0));
        check("reset rst_out", 32'(rst_out), 32'(1));
        check("reset rst_done", 32'(rst_done), 32'(0));

        // Release with both channels running at the default divisor.
        ch_en = 2'b11;
        reset = 1'b0;
        sb_push(0, DEFAULT_DIV + 1, NPUSH);
        sb_push(1, DEFAULT_DIV + 1, NPUSH);
        run(13);

        // ch0: load 0 mid-period; current half-period finishes, then toggles every cycle.
        div_load = 2'b01; div_value = 8'd0; replan(0, 1);
        step();
        div_load = '0;
        step();

        // ch1: load 5 then 1 before its terminal; only 1 is ever applied.
        div_load = 2'b10; div_value = 8'd5; replan(1, 6);
        step();
        div_value = 8'd1; replan(1, 2);
        step();
        div_load = '0;
        run(6);

        // ch1: load 4 exactly on a terminal cycle; the next half-period is 5 cycles.
        div_load = 2'b10; div_value = 8'd4; replan(1, 5);
        step();
        div_load = '0;
        step();

        // ch0: load 3 (terminal every cycle, applied directly), giving a measurable count.
        div_load = 2'b01; div_value = 8'd3; replan(0, 4);
        step();
        div_load = '0;
        run(5);

        // ch0: drop enable while clk_out[0] is high, then restore with a full first half-period.
        ch_en[0]  = 1'b0;
        clr_at[0] = cyc + 1;
        run(3);
        ch_en[0]    = 1'b1;
        last_tog[0] = cyc;
        sb_push(0, 4, NPUSH);
        run(6);

        // Button request: rst_out rises after the synchroniser, channels clear, delay restarts.
        btn_rst_req = 1'b1;
        rst_hi_from = cyc + SYNC_LAT;
        rst_rel_at  = cyc + SYNC_LAT + 1 + DELAY;
        clr_at[0]   = cyc + SYNC_LAT + 1;
        clr_at[1]   = cyc + SYNC_LAT + 1;
        step();
        btn_rst_req = 1'b0;
        run(2);
        sb_push(0, 4, NPUSH);
        sb_push(1, 5, NPUSH);
        run(5);

        // Second one-cycle request at dly_cnt=5: the full delay restarts, divisors retained.
        btn_rst_req = 1'b1;
        rst_rel_at  = cyc + SYNC_LAT + 1 + DELAY;
        clr_at[0]   = cyc + SYNC_LAT + 1;
        clr_at[1]   = cyc + SYNC_LAT + 1;
        step();
        btn_rst_req = 1'b0;
        run(2);
        sb_push(0, 4, NPUSH);
        sb_push(1, 5, NPUSH);
        run(19);

        // Asynchronous reset takes effect without a clock edge.
        reset = 1'b1;
        #1;
        check("async rst_out", 32'(rst_out), 32'(1));
        check("async clk_out", 32'(clk_out), 32'(0));
        check("async tick_out", 32'(tick_out), 32'(0));
        check("async rst_done", 32'(rst_done), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
